// File: rtl/sysa_pkg.sv
// Shared types and constants for the sysa job scheduler and its result buffer.
package sysa_pkg;

    localparam int unsigned N       = 3;
    localparam int unsigned DW      = 8;
    localparam int unsigned AW      = 16;
    localparam int unsigned N_WORDS = 3;
    localparam int unsigned T_LAST  = 5;
    localparam int unsigned N_RES   = N * N;

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StFeed,
        StDrain,
        StOut
    } state_e;

    // Column j emits valid results on steps COL_T0[j] .. COL_T0[j]+2 (skew of one step per column)
    localparam logic [3*3-1:0] COL_T0   = {3'd3, 3'd2, 3'd1};
    // Column j owns buffer entries COL_BASE[j] .. COL_BASE[j]+2
    localparam logic [3*4-1:0] COL_BASE = {4'd6, 4'd3, 4'd0};

    function automatic logic cap_hit(input int col, input logic [2:0] t);
        logic [2:0] t0;
        t0 = COL_T0[3*col +: 3];
        return (t >= t0) && (t <= t0 + 3'd2);
    endfunction

    function automatic logic [3:0] cap_idx(input int col, input logic [2:0] t);
        logic [2:0] t0;
        logic [2:0] off;
        t0  = COL_T0[3*col +: 3];
        off = t - t0;
        return COL_BASE[4*col +: 4] + {1'b0, off};
    endfunction

endpackage

// File: rtl/sysa_sched_if.sv
// Host-side streams of the scheduler: job control, weights, activations and results.
interface sysa_sched_if;
    import sysa_pkg::*;

    logic              start;
    logic              busy;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [31:0]       cfg_data;
    logic              act_valid;
    logic              act_ready;
    logic [N*DW-1:0]   act_data;
    logic              res_valid;
    logic              res_ready;
    logic [AW-1:0]     res_data;
    logic              res_last;

    modport master (
        output start, cfg_valid, cfg_data, act_valid, act_data, res_ready,
        input  busy, cfg_ready, act_ready, res_valid, res_data, res_last
    );

    modport slave (
        input  start, cfg_valid, cfg_data, act_valid, act_data, res_ready,
        output busy, cfg_ready, act_ready, res_valid, res_data, res_last
    );

endinterface

// File: rtl/sysa_res_buf.sv
// 9-entry result buffer: three independent write ports, one read port, synchronous clear.
module sysa_res_buf
    import sysa_pkg::*;
(
    input  logic                   clk,
    input  logic                   clr,
    input  logic [N-1:0]           we,
    input  logic [N-1:0][3:0]      widx,
    input  logic [N-1:0][AW-1:0]   wdata,
    input  logic [3:0]             ridx,
    output logic [AW-1:0]          rdata
);

    logic [N_RES-1:0][AW-1:0] mem_q;

    // Storage update: clear wins, otherwise each port writes its own entry
    always_ff @(posedge clk) begin
        if (clr) begin
            mem_q <= '0;
        end else begin
            for (int i = 0; i < N_RES; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (we[j] && (widx[j] == 4'(i))) begin
                        mem_q[i] <= wdata[j];
                    end
                end
            end
        end
    end

    // Read mux; out-of-range indices read as zero
    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_RES; i++) begin
            if (ridx == 4'(i)) begin
                rdata = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/sysa_sched.sv
// Job scheduler for the 3x3 systolic array: load weights, feed, drain, return results.
module sysa_sched
    import sysa_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    sysa_sched_if.slave       host,
    output logic              sa_en,
    output logic              sa_clr,
    output logic [N*32-1:0]   sa_w,
    output logic [N*DW-1:0]   sa_in,
    input  logic [AW-1:0]     sa_out1,
    input  logic [AW-1:0]     sa_out2,
    input  logic [AW-1:0]     sa_out3
);

    state_e            state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic [2:0]        t_q, t_d;
    logic [3:0]        r_q, r_d;
    logic [N*32-1:0]   w_q, w_d;
    logic [N*DW-1:0]   in_q, in_d;
    logic              clr_q, clr_d;
    logic              start_acc;
    logic              cfg_ready, act_ready, res_valid;

    logic [N-1:0]          cap_we;
    logic [N-1:0][3:0]     cap_widx;
    logic [N-1:0][AW-1:0]  cap_data;
    logic [AW-1:0]         buf_rdata;

    // Next-state, counters and array drive
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        t_d       = t_q;
        r_d       = r_q;
        w_d       = w_q;
        in_d      = in_q;
        clr_d     = 1'b0;
        start_acc = 1'b0;
        cfg_ready = 1'b0;
        act_ready = 1'b0;
        res_valid = 1'b0;
        sa_en     = 1'b0;
        unique case (state_q)
            StIdle: begin
                k_d = '0;
                t_d = '0;
                r_d = '0;
                if (host.start) begin
                    start_acc = 1'b1;
                    clr_d     = 1'b1;
                    state_d   = StLoadW;
                end
            end
            StLoadW: begin
                cfg_ready = 1'b1;
                if (host.cfg_valid) begin
                    w_d[32*int'(k_q) +: 32] = host.cfg_data;
                    k_d = k_q + 3'd1;
                    if (k_q == 3'(N_WORDS - 1)) state_d = StFeed;
                end
            end
            StFeed: begin
                act_ready = 1'b1;
                // Without a vector the array is frozen and sa_in keeps its last value
                if (host.act_valid) begin
                    sa_en = 1'b1;
                    in_d  = host.act_data;
                    t_d   = t_q + 3'd1;
                    if (t_q == 3'(N - 1)) state_d = StDrain;
                end
            end
            StDrain: begin
                sa_en = 1'b1;
                in_d  = '0;
                t_d   = t_q + 3'd1;
                if (t_q == 3'(T_LAST)) state_d = StOut;
            end
            StOut: begin
                res_valid = 1'b1;
                if (host.res_ready) begin
                    r_d = r_q + 4'd1;
                    if (r_q == 4'(N_RES - 1)) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            k_q     <= '0;
            t_q     <= '0;
            r_q     <= '0;
            w_q     <= '0;
            in_q    <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            t_q     <= t_d;
            r_q     <= r_d;
            w_q     <= w_d;
            in_q    <= in_d;
            clr_q   <= clr_d;
        end
    end

    // Capture windows: each column writes its own three entries on enabled steps
    always_comb begin
        cap_we   = '0;
        cap_widx = '0;
        for (int j = 0; j < N; j++) begin
            cap_we[j]   = sa_en && cap_hit(j, t_q);
            cap_widx[j] = cap_idx(j, t_q);
        end
    end

    assign cap_data = {sa_out3, sa_out2, sa_out1};

    sysa_res_buf u_res_buf (
        .clk   (clk),
        .clr   (reset | start_acc),
        .we    (cap_we),
        .widx  (cap_widx),
        .wdata (cap_data),
        .ridx  (r_q),
        .rdata (buf_rdata)
    );

    assign sa_clr         = clr_q;
    assign sa_w           = w_q;
    assign sa_in          = in_d;
    assign host.busy      = (state_q != StIdle);
    assign host.cfg_ready = cfg_ready;
    assign host.act_ready = act_ready;
    assign host.res_valid = res_valid;
    assign host.res_data  = (state_q == StOut) ? buf_rdata : '0;
    assign host.res_last  = (state_q == StOut) && (r_q == 4'(N_RES - 1));

endmodule

// File: tb/tb_sysa_sched.sv
// Directed bench for sysa_sched with a counting stub in place of the array.
module tb_sysa_sched;
    import sysa_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         sa_en, sa_clr;
    logic [95:0]  sa_w;
    logic [23:0]  sa_in;
    logic [15:0]  sa_out1, sa_out2, sa_out3;
    logic [7:0]   en_cnt;
    int           clr_pulses = 0;
    int           cyc = 0;
    int           n_checks = 0;
    int           n_errors = 0;

    localparam logic [95:0] EXP_W = 96'h333333332222222211111111;
    localparam logic [23:0] ACT   = 24'h030201;
    logic [15:0] exp_res [9] = '{16'h0101, 16'h0102, 16'h0103, 16'h0202, 16'h0203,
                                 16'h0204, 16'h0303, 16'h0304, 16'h0305};
    logic [31:0] words [3] = '{32'h11111111, 32'h22222222, 32'h33333333};

    always #5 clk = ~clk;

    sysa_sched_if host_if ();

    sysa_sched u_dut (
        .clk     (clk),
        .reset   (reset),
        .host    (host_if),
        .sa_en   (sa_en),
        .sa_clr  (sa_clr),
        .sa_w    (sa_w),
        .sa_in   (sa_in),
        .sa_out1 (sa_out1),
        .sa_out2 (sa_out2),
        .sa_out3 (sa_out3)
    );

    // Stub array: column j reports {j, enabled cycles completed since the last clear}
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sa_clr) clr_pulses <= clr_pulses + 1;
        if (reset || sa_clr) en_cnt <= '0;
        else if (sa_en)      en_cnt <= en_cnt + 8'd1;
    end

    assign sa_out1 = {8'h01, en_cnt};
    assign sa_out2 = {8'h02, en_cnt};
    assign sa_out3 = {8'h03, en_cnt};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      host_if.busy,      0);
        check({tag, "_cfg_ready"}, host_if.cfg_ready, 0);
        check({tag, "_act_ready"}, host_if.act_ready, 0);
        check({tag, "_res_valid"}, host_if.res_valid, 0);
        check({tag, "_res_last"},  host_if.res_last,  0);
        check({tag, "_res_data"},  host_if.res_data,  0);
        check({tag, "_sa_en"},     sa_en,             0);
        check({tag, "_sa_clr"},    sa_clr,            0);
        check({tag, "_sa_w"},      sa_w,              0);
        check({tag, "_sa_in"},     sa_in,             0);
    endtask

    // One job on a fixed schedule; gap = FEED stall cycles before vector 2,
    // bp = cycles of res_ready low at r=4, poke = drive ignored inputs, abort = reset in DRAIN
    task automatic run_job(input int gap, input int bp, input bit poke, input bit abort);
        int t0;
        @(negedge clk);
        host_if.start = 1'b1;
        #1;
        check("idle_busy", host_if.busy, 0);
        t0 = cyc;
        @(negedge clk);
        host_if.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            host_if.cfg_valid = 1'b1;
            host_if.cfg_data  = words[k];
            #1;
            check("cfg_ready", host_if.cfg_ready, 1);
            check("sa_clr_pulse", sa_clr, (k == 0));
            check("busy_load", host_if.busy, 1);
            @(negedge clk);
        end
        host_if.cfg_valid = 1'b0;
        for (int v = 0; v < 3; v++) begin
            if (v == 1) begin
                for (int g = 0; g < gap; g++) begin
                    host_if.act_valid = 1'b0;
                    #1;
                    check("stall_en", sa_en, 0);
                    check("stall_in_hold", sa_in, ACT);
                    check("stall_act_ready", host_if.act_ready, 1);
                    @(negedge clk);
                end
            end
            host_if.act_valid = 1'b1;
            host_if.act_data  = ACT;
            host_if.start     = poke && (v == 1);
            #1;
            if (v == 0) check("sa_w", sa_w, EXP_W);
            check("feed_en", sa_en, 1);
            check("feed_in", sa_in, ACT);
            check("feed_act_ready", host_if.act_ready, 1);
            check("feed_cfg_ready", host_if.cfg_ready, 0);
            @(negedge clk);
        end
        host_if.act_valid = 1'b0;
        host_if.start     = 1'b0;
        for (int d = 0; d < 3; d++) begin
            if (abort && d == 1) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                #1;
                check_reset_outputs("abort");
                return;
            end
            #1;
            check("drain_en", sa_en, 1);
            check("drain_in", sa_in, 0);
            check("drain_act_ready", host_if.act_ready, 0);
            @(negedge clk);
        end
        #1;
        check("first_valid_latency", cyc - t0, 10 + gap);
        for (int r = 0; r < 9; r++) begin
            if (r == 4) begin
                for (int b = 0; b < bp; b++) begin
                    host_if.res_ready = 1'b0;
                    #1;
                    check("bp_valid", host_if.res_valid, 1);
                    check("bp_data", host_if.res_data, 16'h0203);
                    check("bp_last", host_if.res_last, 0);
                    @(negedge clk);
                end
            end
            host_if.res_ready = 1'b1;
            host_if.cfg_valid = poke;
            #1;
            check("res_valid", host_if.res_valid, 1);
            check("res_data", host_if.res_data, exp_res[r]);
            check("res_last", host_if.res_last, (r == 8));
            check("out_cfg_ready", host_if.cfg_ready, 0);
            @(negedge clk);
        end
        host_if.res_ready = 1'b0;
        host_if.cfg_valid = 1'b0;
        #1;
        check("busy_fall", host_if.busy, 0);
        check("done_res_valid", host_if.res_valid, 0);
        check("job_cycles", cyc - t0, 19 + gap + bp);
    endtask

    initial begin
        reset             = 1'b1;
        host_if.start     = 1'b0;
        host_if.cfg_valid = 1'b0;
        host_if.cfg_data  = '0;
        host_if.act_valid = 1'b0;
        host_if.act_data  = '0;
        host_if.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b0;

        run_job(0, 0, 1'b0, 1'b0);   // basic job
        run_job(4, 0, 1'b0, 1'b0);   // FEED stall
        run_job(0, 3, 1'b0, 1'b0);   // result backpressure
        run_job(0, 0, 1'b0, 1'b1);   // reset in DRAIN
        run_job(0, 0, 1'b0, 1'b0);   // clean job after abort
        run_job(0, 0, 1'b1, 1'b0);   // ignored start / cfg_valid

        check("sa_clr_per_job", clr_pulses, 6);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
